// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: datapath width, NOP encoding, FSM states and
// the IF/ID payload record.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: a load captures {1, pc, pc+4, instr}; clear only
// drops the valid bit, and a load on the same edge wins over clear.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output if_id_t          if_id_o
);

    if_id_t if_id_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q <= '{valid: 1'b0, pc: '0, pc4: '0, instr: INSTR_NOP};
        end else if (load_i) begin
            if_id_q <= '{valid: 1'b1, pc: pc_i, pc4: pc_i + PC_STEP, instr: instr_i};
        end else if (clear_i) begin
            if_id_q.valid <= 1'b0;
        end
    end

    assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem requests, one-word skid
// and the IF/ID register. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] skid_q, skid_d;
    logic            kill_q, kill_d;

    logic            load_en;
    logic            load;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] target;
    if_id_t          if_id;

    assign target  = word_align(redirect_pc);
    assign load_en = !stall || !if_id.valid;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        kill_d     = kill_q;
        load       = 1'b0;
        load_instr = imem_rdata;
        imem_req   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem_req = !redirect;
                if (redirect) pc_d = target;
                else          state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = target;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (kill_q) begin
                        state_d = S_REQ;
                    end else if (load_en) begin
                        load    = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_REQ;
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                load_instr = skid_q;
                // A redirect simply abandons the buffered word.
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (load_en) begin
                    load    = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            skid_q  <= INSTR_NOP;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            kill_q  <= kill_d;
        end
    end

    assign imem_addr = pc_q;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .clear_i (redirect || flush),
        .pc_i    (pc_q),
        .instr_i (load_instr),
        .if_id_o (if_id)
    );

    assign if_valid = if_id.valid;
    assign if_pc    = if_id.pc;
    assign if_pc4   = if_id.pc4;
    assign if_instr = if_id.instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (load)              perf_fetch_q <= perf_fetch_q + 32'd1;
            if (state_q == S_HOLD) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
